// File: rtl/sliding_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sliding_scan_ctrl
//  Purpose  : Scan sequencer for a multiplexed 7-segment sliding-text display.
//             Each accepted scan tick blanks the anodes, addresses the message
//             ROM for the next digit, waits one cycle for the registered ROM,
//             then lights that digit with the fetched pattern. Every SHIFT_DIV
//             complete frames the window offset advances by one character.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1       system clock, rising edge
//    rst         in   1       synchronous reset, active-low
//    tick_scan   in   1       one-cycle scan strobe
//    pause       in   1       freezes the slide offset while high
//    char_addr   out  AW      message ROM address
//    char_data   in   7       ROM pattern (active-low), valid 1 cycle later
//    an          out  DIGITS  anode enables, active-low, one-cold or all high
//    seg         out  7       segment drive, active-low
//    offset      out  AW      window start index, 0..MSG_LEN-1
//    shift_pulse out  1       one-cycle strobe on each offset advance
// ============================================================================
module sliding_scan_ctrl #(
   parameter int DIGITS    = 4,
   parameter int MSG_LEN   = 16,
   parameter int AW        = 4,
   parameter int SHIFT_DIV = 250,
   parameter int FW        = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_scan,
   input  logic              pause,
   output logic [AW-1:0]     char_addr,
   input  logic [6:0]        char_data,
   output logic [DIGITS-1:0] an,
   output logic [6:0]        seg,
   output logic [AW-1:0]     offset,
   output logic              shift_pulse
);

   localparam int c_DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [c_DW-1:0]   c_LAST_DIGIT = c_DW'(DIGITS - 1);
   localparam logic [FW-1:0]     c_LAST_FRAME = FW'(SHIFT_DIV - 1);
   localparam logic [AW-1:0]     c_LAST_CHAR  = AW'(MSG_LEN - 1);
   localparam logic [AW:0]       c_MSG_LEN    = (AW+1)'(MSG_LEN);
   localparam logic [AW:0]       c_SPAN       = (AW+1)'(DIGITS - 1);
   localparam logic [DIGITS-1:0] c_AN_ONE     = DIGITS'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_LATCH = 2'd2
   } state_t;

   state_t            r_state, w_state;
   // r_digit is the digit the next accepted tick will display;
   // r_cur is the digit currently being fetched / shown.
   logic [c_DW-1:0]   r_digit, w_digit;
   logic [c_DW-1:0]   r_cur, w_cur;
   logic [FW-1:0]     r_frame, w_frame;
   logic [AW-1:0]     r_offset, w_offset;
   logic [AW-1:0]     r_addr, w_addr;
   logic [DIGITS-1:0] r_an, w_an;
   logic [6:0]        r_seg, w_seg;
   logic              r_pulse, w_pulse;

   logic [AW:0]       w_sum;
   logic [AW:0]       w_wrapped;
   logic [AW-1:0]     w_addr_calc;
   logic              w_digit_last;

   // Digit d shows character (offset + DIGITS-1-d) mod MSG_LEN. The sum is
   // below 2*MSG_LEN, so one conditional subtract reduces it.
   assign w_sum        = {1'b0, r_offset} + c_SPAN - (AW+1)'(r_digit);
   assign w_wrapped    = (w_sum >= c_MSG_LEN) ? (w_sum - c_MSG_LEN) : w_sum;
   assign w_addr_calc  = w_wrapped[AW-1:0];
   assign w_digit_last = (r_digit == c_LAST_DIGIT);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_digit  <= '0;
         r_cur    <= '0;
         r_frame  <= '0;
         r_offset <= '0;
         r_addr   <= '0;
         r_an     <= '1;
         r_seg    <= 7'h7F;
         r_pulse  <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_digit  <= w_digit;
         r_cur    <= w_cur;
         r_frame  <= w_frame;
         r_offset <= w_offset;
         r_addr   <= w_addr;
         r_an     <= w_an;
         r_seg    <= w_seg;
         r_pulse  <= w_pulse;
      end
   end

   always_comb begin
      w_state  = r_state;
      w_digit  = r_digit;
      w_cur    = r_cur;
      w_frame  = r_frame;
      w_offset = r_offset;
      w_addr   = r_addr;
      w_an     = r_an;
      w_seg    = r_seg;
      w_pulse  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (tick_scan) begin
               w_state = S_FETCH;
               w_an    = '1;
               w_addr  = w_addr_calc;
               w_cur   = r_digit;
               w_digit = w_digit_last ? '0 : r_digit + 1'b1;
               // Offset changes only as the last digit of a frame is taken,
               // so the whole next frame is addressed with the new offset.
               if (w_digit_last) begin
                  if (pause) begin
                     w_frame = '0;
                  end else if (r_frame == c_LAST_FRAME) begin
                     w_frame  = '0;
                     w_offset = (r_offset == c_LAST_CHAR) ? '0 : r_offset + 1'b1;
                     w_pulse  = 1'b1;
                  end else begin
                     w_frame = r_frame + 1'b1;
                  end
               end
            end
         end
         S_FETCH: begin
            w_state = S_LATCH;
         end
         S_LATCH: begin
            w_seg   = char_data;
            w_an    = ~(c_AN_ONE << r_cur);
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   assign char_addr   = r_addr;
   assign an          = r_an;
   assign seg         = r_seg;
   assign offset      = r_offset;
   assign shift_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_sliding_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sliding_scan_ctrl
//  Purpose  : Self-checking bench for sliding_scan_ctrl (DIGITS=4, MSG_LEN=6,
//             SHIFT_DIV=2). A registered ROM model returns {4'h0, addr}.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sliding_scan_ctrl;

   localparam int DIGITS    = 4;
   localparam int MSG_LEN   = 6;
   localparam int AW        = 3;
   localparam int SHIFT_DIV = 2;
   localparam int FW        = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          tick_scan = 1'b0;
   logic          pause = 1'b0;
   logic [AW-1:0] char_addr;
   logic [6:0]    char_data;
   logic [3:0]    an;
   logic [6:0]    seg;
   logic [AW-1:0] offset;
   logic          shift_pulse;

   int checks = 0;
   int errors = 0;

   // Reference model: window offset, frame count, next digit to show.
   int m_offset = 0;
   int m_frame  = 0;
   int m_digit  = 0;

   always #5 clk = ~clk;

   logic [6:0] r_rom_q = 7'h00;
   always @(posedge clk) r_rom_q <= {4'h0, char_addr};
   assign char_data = r_rom_q;

   sliding_scan_ctrl #(
      .DIGITS(DIGITS), .MSG_LEN(MSG_LEN), .AW(AW), .SHIFT_DIV(SHIFT_DIV), .FW(FW)
   ) dut (
      .clk(clk), .rst(rst), .tick_scan(tick_scan), .pause(pause),
      .char_addr(char_addr), .char_data(char_data), .an(an), .seg(seg),
      .offset(offset), .shift_pulse(shift_pulse)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_offset = 0;
      m_frame  = 0;
      m_digit  = 0;
   endfunction

   // One accepted tick plus the idle cycles after it. Entered and left just
   // after a falling edge with the DUT idle. drop=1/2 raises tick_scan again
   // during the FETCH/LATCH cycle, which must be ignored.
   task automatic run_tick(input logic p, input int drop, input int gap,
                           output logic [2:0] o_addr, output logic [3:0] o_an,
                           output logic o_pulse, output logic [2:0] o_off);
      int         d;
      logic [2:0] ea;
      logic       ep;
      logic [3:0] ean;
      logic [6:0] seg_prev;
      d  = m_digit;
      ea = 3'((m_offset + (DIGITS - 1 - d)) % MSG_LEN);
      ep = 1'b0;
      if (d == DIGITS - 1) begin
         if (p) m_frame = 0;
         else if (m_frame == SHIFT_DIV - 1) begin
            m_frame  = 0;
            m_offset = (m_offset + 1) % MSG_LEN;
            ep       = 1'b1;
         end else m_frame = m_frame + 1;
      end
      m_digit  = (d + 1) % DIGITS;
      ean      = ~(4'b0001 << d);
      seg_prev = seg;

      pause = p;
      tick_scan = 1'b1;
      @(posedge clk); @(negedge clk);
      o_addr  = char_addr;
      o_pulse = shift_pulse;
      o_off   = offset;
      chk("addr", 32'(char_addr), 32'(ea));
      chk("blank_a", 32'(an), 32'hF);
      chk("pulse", 32'(shift_pulse), 32'(ep));
      chk("offset", 32'(offset), 32'(m_offset));
      tick_scan = (drop == 1);
      @(posedge clk); @(negedge clk);
      chk("blank_b", 32'(an), 32'hF);
      chk("seg_hold", 32'(seg), 32'(seg_prev));
      chk("pulse_lo", 32'(shift_pulse), 32'h0);
      tick_scan = (drop == 2);
      @(posedge clk); @(negedge clk);
      tick_scan = 1'b0;
      o_an = an;
      chk("an_lit", 32'(an), 32'(ean));
      chk("seg_lit", 32'(seg), 32'({4'h0, ea}));
      chk("pulse_lo", 32'(shift_pulse), 32'h0);
      for (int i = 3; i < gap; i++) begin
         @(posedge clk); @(negedge clk);
         chk("an_hold", 32'(an), 32'(ean));
         chk("pulse_idle", 32'(shift_pulse), 32'h0);
      end
   endtask

   typedef struct {
      logic       p;
      logic [2:0] addr;
      logic [3:0] an;
      logic [2:0] off;
      logic       pulse;
   } vec_t;

   vec_t tbl [12];

   initial begin
      logic [2:0] ra;
      logic [3:0] rn;
      logic       rp;
      logic [2:0] ro;
      int         off_before;
      int         npulse;
      int         guard;
      logic [2:0] wrap_exp [4];
      logic [2:0] wrap_got [4];

      // scan order from reset: two frames at offset 0, the second ends in a
      // slide, then the first frame at offset 1
      tbl[0]  = '{1'b0, 3'd3, 4'hE, 3'd0, 1'b0};
      tbl[1]  = '{1'b0, 3'd2, 4'hD, 3'd0, 1'b0};
      tbl[2]  = '{1'b0, 3'd1, 4'hB, 3'd0, 1'b0};
      tbl[3]  = '{1'b0, 3'd0, 4'h7, 3'd0, 1'b0};
      tbl[4]  = '{1'b0, 3'd3, 4'hE, 3'd0, 1'b0};
      tbl[5]  = '{1'b0, 3'd2, 4'hD, 3'd0, 1'b0};
      tbl[6]  = '{1'b0, 3'd1, 4'hB, 3'd0, 1'b0};
      tbl[7]  = '{1'b0, 3'd0, 4'h7, 3'd1, 1'b1};
      tbl[8]  = '{1'b0, 3'd4, 4'hE, 3'd1, 1'b0};
      tbl[9]  = '{1'b0, 3'd3, 4'hD, 3'd1, 1'b0};
      tbl[10] = '{1'b0, 3'd2, 4'hB, 3'd1, 1'b0};
      tbl[11] = '{1'b0, 3'd1, 4'h7, 3'd1, 1'b0};
      wrap_exp[0] = 3'd2; wrap_exp[1] = 3'd1; wrap_exp[2] = 3'd0; wrap_exp[3] = 3'd5;

      // reset held with tick_scan toggling
      rst = 1'b0;
      tick_scan = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         chk("rst_an", 32'(an), 32'hF);
         chk("rst_seg", 32'(seg), 32'h7F);
         chk("rst_offset", 32'(offset), 32'h0);
         chk("rst_pulse", 32'(shift_pulse), 32'h0);
         tick_scan = ~tick_scan;
      end
      tick_scan = 1'b0;
      rst = 1'b1;
      model_reset();
      @(posedge clk); @(negedge clk);

      // table-driven scan order and first slide
      for (int k = 0; k < 12; k++) begin
         run_tick(tbl[k].p, 0, 10, ra, rn, rp, ro);
         chk($sformatf("tbl%0d_addr", k), 32'(ra), 32'(tbl[k].addr));
         chk($sformatf("tbl%0d_an", k), 32'(rn), 32'(tbl[k].an));
         chk($sformatf("tbl%0d_off", k), 32'(ro), 32'(tbl[k].off));
         chk($sformatf("tbl%0d_pulse", k), 32'(rp), 32'(tbl[k].pulse));
      end

      // slide to offset 5: digit addresses wrap, next step returns to 0
      guard = 0;
      while (!(m_offset == 5 && m_digit == 0) && guard < 400) begin
         run_tick(1'b0, 0, 10, ra, rn, rp, ro);
         guard++;
      end
      chk("reach_off5", 32'(m_offset == 5 && m_digit == 0), 32'h1);
      for (int k = 0; k < 4; k++) begin
         run_tick(1'b0, 0, 10, ra, rn, rp, ro);
         wrap_got[k] = ra;
      end
      for (int k = 0; k < 4; k++) chk($sformatf("wrap_addr%0d", k), 32'(wrap_got[k]), 32'(wrap_exp[k]));
      guard = 0;
      rp = 1'b0;
      while (!rp && guard < 8) begin
         run_tick(1'b0, 0, 10, ra, rn, rp, ro);
         guard++;
      end
      chk("wrap_to_zero", 32'(ro), 32'h0);

      // pause for 10 frames, then two frames to the next slide
      while (m_digit != 0) run_tick(1'b0, 0, 10, ra, rn, rp, ro);
      off_before = int'(offset);
      npulse = 0;
      for (int k = 0; k < 10 * DIGITS; k++) begin
         run_tick(1'b1, 0, 10, ra, rn, rp, ro);
         if (rp) npulse++;
      end
      chk("pause_offset", 32'(offset), 32'(off_before));
      chk("pause_pulses", 32'(npulse), 32'h0);
      for (int k = 0; k < 2 * DIGITS; k++) begin
         run_tick(1'b0, 0, 10, ra, rn, rp, ro);
         if (rp) npulse++;
         if (k == 2 * DIGITS - 2) chk("resume_early", 32'(npulse), 32'h0);
      end
      chk("resume_pulse", 32'(npulse), 32'h1);
      chk("resume_offset", 32'(offset), 32'((off_before + 1) % MSG_LEN));

      // dropped ticks during FETCH and LATCH
      for (int k = 0; k < 2 * DIGITS; k++) run_tick(1'b0, 1 + (k % 2), 10, ra, rn, rp, ro);

      // reset during FETCH with offset 3
      guard = 0;
      while (!(m_offset == 3 && m_digit == 0) && guard < 400) begin
         run_tick(1'b0, 0, 10, ra, rn, rp, ro);
         guard++;
      end
      chk("reach_off3", 32'(offset), 32'h3);
      tick_scan = 1'b1;
      @(posedge clk); @(negedge clk);
      tick_scan = 1'b0;
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("abort_an", 32'(an), 32'hF);
      chk("abort_offset", 32'(offset), 32'h0);
      chk("abort_addr", 32'(char_addr), 32'h0);
      chk("abort_seg", 32'(seg), 32'h7F);
      chk("abort_pulse", 32'(shift_pulse), 32'h0);
      rst = 1'b1;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); @(negedge clk);
         chk("abort_seg_hold", 32'(seg), 32'h7F);
         chk("abort_an_hold", 32'(an), 32'hF);
      end
      run_tick(1'b0, 0, 10, ra, rn, rp, ro);
      chk("after_abort_addr", 32'(ra), 32'h3);
      chk("after_abort_an", 32'(rn), 32'hE);

      // randomized ticks, pause, drops and tick spacing against the model
      for (int k = 0; k < 160; k++) begin
         run_tick(($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)),
                  int'($urandom_range(3, 12)), ra, rn, rp, ro);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
